// File: rtl/life_array_nxm_pkg.sv
// life_pkg: Life rule constants and the column-major cell index helper.
package life_pkg;
    localparam int NBR_W = 4;
    localparam logic [NBR_W-1:0] BIRTH_N = 4'd3;
    localparam logic [NBR_W-1:0] SURVIVE_N = 4'd2;
    function automatic int idx(input int row, input int col, input int rows);
        return col * rows + row;
    endfunction
endpackage

// File: rtl/life_array_nxm_if.sv
// life_array_nxm_if: host-side bus of the Life grid (load, scan, run control, status).
interface life_array_nxm_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int GEN_W = 16
);
    logic [ROWS*COLS-1:0] alive;
    logic [$clog2(ROWS)-1:0] row;
    logic [$clog2(COLS)-1:0] col;
    logic val;
    logic write_enb;
    logic scan;
    logic scan_write_val;
    logic scan_write_enb;
    logic scan_read_val;
    logic run;
    logic step;
    logic [GEN_W-1:0] gen_count;
    logic stable;
    logic extinct;
    modport master (
        output row, col, val, write_enb, scan, scan_write_val, scan_write_enb, run, step,
        input  alive, scan_read_val, gen_count, stable, extinct
    );
    modport slave (
        input  row, col, val, write_enb, scan, scan_write_val, scan_write_enb, run, step,
        output alive, scan_read_val, gen_count, stable, extinct
    );
endinterface

// File: rtl/life_array_nxm_cell.sv
// life_cell_n8: one Conway cell with scan, direct load and generation advance.
module life_cell_n8
    import life_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_nbr,
    input  logic       i_scan,
    input  logic       i_scan_in,
    input  logic       i_load,
    input  logic       i_val,
    input  logic       i_adv,
    output logic       o_d,
    output logic       o_alive
);
    logic [NBR_W-1:0] w_n;
    logic r_alive;
    always_comb begin
        w_n = '0;
        for (int k = 0; k < 8; k++) w_n = w_n + NBR_W'(i_nbr[k]);
        o_d = i_scan ? i_scan_in :
              i_load ? i_val :
              i_adv  ? ((w_n == BIRTH_N) | (r_alive & (w_n == SURVIVE_N))) : r_alive;
    end
    always_ff @(posedge clk) r_alive <= reset ? 1'b0 : o_d;
    assign o_alive = r_alive;
endmodule

// File: rtl/life_array_nxm.sv
// life_array_nxm: ROWS x COLS Life grid with edge wrap option, scan chain and generation controller.
module life_array_nxm
    import life_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int WRAP = 0,
    parameter int GEN_W = 16
) (
    input logic clk,
    input logic reset,
    life_array_nxm_if.slave bus
);
    localparam int N = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    logic [N-1:0] w_alive, w_d, w_scan_in;
    logic w_head, w_adv, w_load_cyc, w_addr_ok;
    logic [GEN_W-1:0] r_gen;
    logic r_stable, r_extinct;
    assign w_head = bus.scan_write_enb ? bus.scan_write_val : w_alive[N-1];
    assign w_scan_in = {w_alive[N-2:0], w_head};
    assign w_addr_ok = (int'(bus.row) < ROWS) && (int'(bus.col) < COLS);
    assign w_load_cyc = bus.scan | (bus.write_enb & w_addr_ok);
    assign w_adv = (bus.run | bus.step) & ~bus.scan & ~bus.write_enb;
    genvar r, c, i, j;
    for (r = 0; r < ROWS; r++) begin : g_row
        for (c = 0; c < COLS; c++) begin : g_col
            localparam int K = idx(r, c, ROWS);
            logic [7:0] w_nbr;
            for (i = 0; i < 3; i++) begin : g_di
                for (j = 0; j < 3; j++) begin : g_dj
                    localparam int RR = r + i - 1;
                    localparam int CC = c + j - 1;
                    localparam int WR = (RR + ROWS) % ROWS;
                    localparam int WC = (CC + COLS) % COLS;
                    localparam bit IN = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                    localparam int B = i * 3 + j;
                    // B==4 is the cell itself; off-grid neighbours read dead unless wrapping
                    if (B != 4) begin : g_b
                        assign w_nbr[B > 4 ? B - 1 : B] = (WRAP != 0 || IN) ? w_alive[idx(WR, WC, ROWS)] : 1'b0;
                    end
                end
            end
            life_cell_n8 u_cell (
                .clk      (clk),
                .reset    (reset),
                .i_nbr    (w_nbr),
                .i_scan   (bus.scan),
                .i_scan_in(w_scan_in[K]),
                .i_load   (bus.write_enb && bus.row == RW'(r) && bus.col == CW'(c)),
                .i_val    (bus.val),
                .i_adv    (w_adv),
                .o_d      (w_d[K]),
                .o_alive  (w_alive[K])
            );
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gen <= '0;
            r_stable <= 1'b0;
            r_extinct <= 1'b1;
        end else if (w_load_cyc) begin
            r_gen <= '0;
            r_stable <= 1'b0;
            r_extinct <= ~|w_d;
        end else if (w_adv) begin
            r_gen <= r_gen + 1'b1;
            r_stable <= (w_d == w_alive);
            r_extinct <= ~|w_d;
        end
    end
    assign bus.alive = w_alive;
    assign bus.scan_read_val = w_alive[N-1];
    assign bus.gen_count = r_gen;
    assign bus.stable = r_stable;
    assign bus.extinct = r_extinct;
endmodule

// File: tb/tb_life_array_nxm.sv
// tb_life_array_nxm: directed checks of a 4x4 bounded grid and 6x6 wrapped/bounded grids.
module tb_life_array_nxm;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_total = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    life_array_nxm_if #(.ROWS(4), .COLS(4), .GEN_W(16)) if4 ();
    life_array_nxm_if #(.ROWS(6), .COLS(6), .GEN_W(16)) if6w ();
    life_array_nxm_if #(.ROWS(6), .COLS(6), .GEN_W(16)) if6n ();
    life_array_nxm #(.ROWS(4), .COLS(4), .WRAP(0), .GEN_W(16)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));
    life_array_nxm #(.ROWS(6), .COLS(6), .WRAP(1), .GEN_W(16)) u_dut6w (.clk(clk), .reset(reset), .bus(if6w));
    life_array_nxm #(.ROWS(6), .COLS(6), .WRAP(0), .GEN_W(16)) u_dut6n (.clk(clk), .reset(reset), .bus(if6n));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_all();
        if4.row = '0; if4.col = '0; if4.val = 0; if4.write_enb = 0; if4.scan = 0;
        if4.scan_write_val = 0; if4.scan_write_enb = 0; if4.run = 0; if4.step = 0;
        if6w.row = '0; if6w.col = '0; if6w.val = 0; if6w.write_enb = 0; if6w.scan = 0;
        if6w.scan_write_val = 0; if6w.scan_write_enb = 0; if6w.run = 0; if6w.step = 0;
        if6n.row = '0; if6n.col = '0; if6n.val = 0; if6n.write_enb = 0; if6n.scan = 0;
        if6n.scan_write_val = 0; if6n.scan_write_enb = 0; if6n.run = 0; if6n.step = 0;
    endtask
    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
    task automatic wr4(input int r, input int c, input bit v);
        if4.row = 2'(r); if4.col = 2'(c); if4.val = v; if4.write_enb = 1;
        tick();
        if4.write_enb = 0;
    endtask
    task automatic wr6(input int r, input int c, input bit v);
        if6w.row = 3'(r); if6w.col = 3'(c); if6w.val = v; if6w.write_enb = 1;
        if6n.row = 3'(r); if6n.col = 3'(c); if6n.val = v; if6n.write_enb = 1;
        tick();
        if6w.write_enb = 0;
        if6n.write_enb = 0;
    endtask
    task automatic step4();
        if4.step = 1;
        tick();
        if4.step = 0;
    endtask
    task automatic test_reset();
        do_reset();
        n_total += 5;
        if (if4.alive !== 16'h0) begin n_bad++; $display("FAIL reset_alive: got %h want 0000", if4.alive); end
        if (if4.gen_count !== 16'd0) begin n_bad++; $display("FAIL reset_gen: got %0d want 0", if4.gen_count); end
        if (if4.stable !== 1'b0) begin n_bad++; $display("FAIL reset_stable: got %b want 0", if4.stable); end
        if (if4.extinct !== 1'b1) begin n_bad++; $display("FAIL reset_extinct: got %b want 1", if4.extinct); end
        if (if6w.alive !== 36'h0) begin n_bad++; $display("FAIL reset_alive6: got %h want 0", if6w.alive); end
    endtask
    task automatic test_blinker();
        do_reset();
        wr4(1, 0, 1); wr4(1, 1, 1); wr4(1, 2, 1);
        n_total += 2;
        if (if4.alive !== 16'h0222) begin n_bad++; $display("FAIL blink_load: got %h want 0222", if4.alive); end
        if (if4.extinct !== 1'b0) begin n_bad++; $display("FAIL blink_load_extinct: got %b want 0", if4.extinct); end
        step4();
        n_total += 3;
        if (if4.alive !== 16'h0070) begin n_bad++; $display("FAIL blink_g1: got %h want 0070", if4.alive); end
        if (if4.gen_count !== 16'd1) begin n_bad++; $display("FAIL blink_g1_gen: got %0d want 1", if4.gen_count); end
        if (if4.stable !== 1'b0) begin n_bad++; $display("FAIL blink_g1_stable: got %b want 0", if4.stable); end
        step4();
        n_total += 2;
        if (if4.alive !== 16'h0222) begin n_bad++; $display("FAIL blink_g2: got %h want 0222", if4.alive); end
        if (if4.gen_count !== 16'd2) begin n_bad++; $display("FAIL blink_g2_gen: got %0d want 2", if4.gen_count); end
        tick();
        tick();
        n_total += 2;
        if (if4.alive !== 16'h0222) begin n_bad++; $display("FAIL blink_idle: got %h want 0222", if4.alive); end
        if (if4.gen_count !== 16'd2) begin n_bad++; $display("FAIL blink_idle_gen: got %0d want 2", if4.gen_count); end
    endtask
    task automatic test_block();
        do_reset();
        wr4(1, 1, 1); wr4(1, 2, 1); wr4(2, 1, 1); wr4(2, 2, 1);
        if4.run = 1;
        tick(); tick(); tick();
        if4.run = 0;
        n_total += 4;
        if (if4.alive !== 16'h0660) begin n_bad++; $display("FAIL block_alive: got %h want 0660", if4.alive); end
        if (if4.stable !== 1'b1) begin n_bad++; $display("FAIL block_stable: got %b want 1", if4.stable); end
        if (if4.gen_count !== 16'd3) begin n_bad++; $display("FAIL block_gen: got %0d want 3", if4.gen_count); end
        if (if4.extinct !== 1'b0) begin n_bad++; $display("FAIL block_extinct: got %b want 0", if4.extinct); end
    endtask
    task automatic test_glider();
        logic [35:0] glider = 36'h0_0000_6144;
        logic [35:0] corner = 36'hC_3000_0000;
        do_reset();
        wr6(0, 1, 1); wr6(1, 2, 1); wr6(2, 0, 1); wr6(2, 1, 1); wr6(2, 2, 1);
        if6w.run = 1;
        if6n.run = 1;
        for (int k = 0; k < 24; k++) tick();
        if6w.run = 0;
        if6n.run = 0;
        n_total += 5;
        if (if6w.alive !== glider) begin n_bad++; $display("FAIL glider_wrap: got %h want %h", if6w.alive, glider); end
        if (if6w.gen_count !== 16'd24) begin n_bad++; $display("FAIL glider_wrap_gen: got %0d want 24", if6w.gen_count); end
        if (if6n.alive !== corner) begin n_bad++; $display("FAIL glider_edge: got %h want %h", if6n.alive, corner); end
        if (if6n.stable !== 1'b1) begin n_bad++; $display("FAIL glider_edge_stable: got %b want 1", if6n.stable); end
        if (if6n.gen_count !== 16'd24) begin n_bad++; $display("FAIL glider_edge_gen: got %0d want 24", if6n.gen_count); end
        if6w.row = 3'd6; if6w.col = 3'd0; if6w.val = 1; if6w.write_enb = 1;
        tick();
        if6w.row = 3'd0; if6w.col = 3'd7;
        tick();
        if6w.write_enb = 0;
        n_total++;
        if (if6w.alive !== glider) begin n_bad++; $display("FAIL oob_write: got %h want %h", if6w.alive, glider); end
    endtask
    task automatic test_scan();
        logic [15:0] p = 16'h8421;
        do_reset();
        if4.scan = 1;
        if4.scan_write_enb = 1;
        for (int k = 15; k >= 0; k--) begin
            if4.scan_write_val = p[k];
            tick();
        end
        if4.scan_write_enb = 0;
        if4.scan_write_val = 0;
        n_total += 2;
        if (if4.alive !== 16'h8421) begin n_bad++; $display("FAIL scan_inject: got %h want 8421", if4.alive); end
        if (if4.gen_count !== 16'd0) begin n_bad++; $display("FAIL scan_inject_gen: got %0d want 0", if4.gen_count); end
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (if4.scan_read_val !== p[15-k]) begin
                n_bad++;
                $display("FAIL scan_read[%0d]: got %b want %b", k, if4.scan_read_val, p[15-k]);
            end
            tick();
        end
        if4.scan = 0;
        n_total++;
        if (if4.alive !== 16'h8421) begin n_bad++; $display("FAIL scan_rotate: got %h want 8421", if4.alive); end
        step4();
        n_total += 2;
        if (if4.alive !== 16'h0420) begin n_bad++; $display("FAIL diag_step: got %h want 0420", if4.alive); end
        if (if4.gen_count !== 16'd1) begin n_bad++; $display("FAIL diag_step_gen: got %0d want 1", if4.gen_count); end
        if4.scan = 1;
        if4.scan_write_enb = 1;
        if4.scan_write_val = 1;
        for (int k = 0; k < 16; k++) tick();
        idle_all();
        n_total += 3;
        if (if4.alive !== 16'hFFFF) begin n_bad++; $display("FAIL scan_ones: got %h want ffff", if4.alive); end
        if (if4.gen_count !== 16'd0) begin n_bad++; $display("FAIL scan_ones_gen: got %0d want 0", if4.gen_count); end
        if (if4.extinct !== 1'b0) begin n_bad++; $display("FAIL scan_ones_extinct: got %b want 0", if4.extinct); end
    endtask
    task automatic test_priority();
        do_reset();
        wr4(1, 0, 1); wr4(1, 1, 1); wr4(1, 2, 1);
        step4();
        if4.step = 1; if4.write_enb = 1; if4.row = 2'd3; if4.col = 2'd3; if4.val = 1; if4.scan = 1;
        tick();
        if4.scan = 0;
        n_total += 3;
        if (if4.alive !== 16'h00E0) begin n_bad++; $display("FAIL prio_scan: got %h want 00e0", if4.alive); end
        if (if4.gen_count !== 16'd0) begin n_bad++; $display("FAIL prio_scan_gen: got %0d want 0", if4.gen_count); end
        if (if4.stable !== 1'b0) begin n_bad++; $display("FAIL prio_scan_stable: got %b want 0", if4.stable); end
        tick();
        idle_all();
        n_total += 2;
        if (if4.alive !== 16'h80E0) begin n_bad++; $display("FAIL prio_write: got %h want 80e0", if4.alive); end
        if (if4.gen_count !== 16'd0) begin n_bad++; $display("FAIL prio_write_gen: got %0d want 0", if4.gen_count); end
        do_reset();
        wr4(0, 0, 1);
        n_total++;
        if (if4.extinct !== 1'b0) begin n_bad++; $display("FAIL lone_extinct0: got %b want 0", if4.extinct); end
        step4();
        n_total += 3;
        if (if4.alive !== 16'h0000) begin n_bad++; $display("FAIL lone_alive: got %h want 0000", if4.alive); end
        if (if4.extinct !== 1'b1) begin n_bad++; $display("FAIL lone_extinct1: got %b want 1", if4.extinct); end
        if (if4.gen_count !== 16'd1) begin n_bad++; $display("FAIL lone_gen: got %0d want 1", if4.gen_count); end
    endtask
    task automatic test_reset_mid_run();
        do_reset();
        wr4(1, 0, 1); wr4(1, 1, 1); wr4(1, 2, 1);
        if4.run = 1;
        tick(); tick(); tick();
        n_total++;
        if (if4.alive !== 16'h0070) begin n_bad++; $display("FAIL midrun_pre: got %h want 0070", if4.alive); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total += 4;
        if (if4.alive !== 16'h0000) begin n_bad++; $display("FAIL midrun_alive: got %h want 0000", if4.alive); end
        if (if4.gen_count !== 16'd0) begin n_bad++; $display("FAIL midrun_gen: got %0d want 0", if4.gen_count); end
        if (if4.extinct !== 1'b1) begin n_bad++; $display("FAIL midrun_extinct: got %b want 1", if4.extinct); end
        if (if4.stable !== 1'b0) begin n_bad++; $display("FAIL midrun_stable: got %b want 0", if4.stable); end
        tick(); tick(); tick();
        if4.run = 0;
        n_total += 3;
        if (if4.alive !== 16'h0000) begin n_bad++; $display("FAIL midrun_dead: got %h want 0000", if4.alive); end
        if (if4.extinct !== 1'b1) begin n_bad++; $display("FAIL midrun_dead_extinct: got %b want 1", if4.extinct); end
        if (if4.gen_count !== 16'd3) begin n_bad++; $display("FAIL midrun_dead_gen: got %0d want 3", if4.gen_count); end
    endtask
    initial begin
        idle_all();
        test_reset();
        test_blinker();
        test_block();
        test_glider();
        test_scan();
        test_priority();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/life_array_nxm.md
Name: life_array_nxm

Overview:
- Parametrised successor to the fixed 4x4 Life tile array: a ROWS x COLS grid of Conway cells.
- Optional toroidal edge wrap, random-access cell write and a full-grid rotating scan chain.
- Built-in generation controller: free-run or single-step, generation counter, stable/extinct status.
- Sits between the host/loader logic and the display/readback path.

Parameters:
- ROWS, 4, grid rows (>=3).
- COLS, 4, grid columns (>=3).
- WRAP, 0, 1 = toroidal neighbours (edges wrap); 0 = cells outside the grid are dead.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- alive  out  ROWS*COLS  cell state, column-major: bit index = col*ROWS + row.
- row  in  clog2(ROWS)  write row address.
- col  in  clog2(COLS)  write column address.
- val  in  1  value to write.
- write_enb  in  1  write val into cell (row,col).
- scan  in  1  shift the scan chain one position this cycle.
- scan_write_val  in  1  serial value injected at chain head.
- scan_write_enb  in  1  inject scan_write_val instead of rotating.
- scan_read_val  out  1  alive[ROWS*COLS-1], the tail of the chain.
- run  in  1  level: advance one generation every cycle.
- step  in  1  pulse: advance exactly one generation.
- gen_count  out  GEN_W  generations computed since reset or last load.
- stable  out  1  last generation produced no change.
- extinct  out  1  all cells dead.

Behaviour:
- Reset: alive=0, gen_count=0, stable=0, extinct=1. Reset asserted mid-run overrides all other inputs that cycle.
- Priority per cycle: reset > scan > write_enb > generation advance. Only one action takes effect per edge.
- Scan (scan=1):
  - Every cell k>0 takes alive[k-1].
  - Cell 0 takes scan_write_enb ? scan_write_val : alive[N-1] (rotate), where N = ROWS*COLS.
  - N scans with scan_write_enb=0 restore the original grid.
- Write (write_enb=1, scan=0): only cell (row,col) is updated. An out-of-range address is ignored with no state change.
- Load effect: any scan or write cycle clears gen_count and stable.
- Generation advance:
  - Occurs when (run | step) & ~scan & ~write_enb; step while run is high has no extra effect.
  - All cells update simultaneously from the previous state: next = (n==3) | (alive & n==2), where n = live count of the 8 neighbours (4-bit).
  - WRAP=0: out-of-grid neighbours read 0. WRAP=1: indices are taken modulo ROWS/COLS.
- Latency: alive reflects the new generation one clock after the advancing edge condition. gen_count increments on the same edge and wraps modulo 2^GEN_W.
- stable: registered on each advance as (next == alive). It holds its value on idle cycles.
- extinct: registered, equal to (alive_next == 0) on every state-changing edge; valid one cycle after any change.
- Idle cycles (no reset/scan/write/advance): all state holds.

Decomposition:
- Shared package life_pkg holds:
  - birth/survive constants (BIRTH_N=3, SURVIVE_N=2).
  - the cell index function idx(row,col) = col*ROWS+row.
  - the neighbour-count width constant (4).
- One natural sub-module: life_cell_n8.
  - Inputs: 8 neighbour bits, scan_in, load value/enable, advance.
  - Output: its state register.
  - The top generates the ROWS x COLS instance array, wrap muxing, the scan chain and the controller.

Test Plan:
- Blinker, 4x4, WRAP=0: write cells (1,0),(1,1),(1,2); pulse step -> alive shows (0,1),(1,1),(2,1), gen_count=1, stable=0. Step again -> original pattern, gen_count=2.
- Block, 4x4: write (1,1),(1,2),(2,1),(2,2); run for 3 cycles -> pattern unchanged, stable=1, gen_count=3, extinct=0.
- Glider, 6x6, WRAP=1: load a glider and run 24 generations -> alive equals the initial pattern, gen_count=24. The same pattern with WRAP=0 -> it decays into an edge still-life, with no bits appearing at wrapped positions.
- Scan: load 0x8421 in 4x4.
  - 16 scan cycles with scan_write_enb=0 -> alive=0x8421, scan_read_val sequence matches bits 15..0.
  - 16 scans injecting 1s -> alive=0xFFFF, gen_count=0.
- Priority: step, write_enb and scan asserted together -> only the scan shift occurs and gen_count is cleared. Single isolated cell + step -> extinct=1 next cycle.
- Reset mid-run: run=1 with a blinker; assert reset for one cycle -> alive=0, gen_count=0, extinct=1, stable=0. Grid stays 0 while run remains high.
